// File: rtl/tff_seq_ctrl_if.sv
// ============================================================================
// Module      : tff_seq_ctrl_if
// Description : Control/status bundle between a sequence controller and the
//               T flip-flop bank it drives (commands, toggle enables, status).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tff_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    // command and configuration
    logic             start;
    logic             stop;
    logic             pause;
    logic             dir;
    logic [WIDTH-1:0] limit;
    // bank feedback and drive
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t;
    logic             tff_clr;
    // status
    logic             busy;
    logic             done;
    logic             aborted;
    logic [WIDTH:0]   steps;

    // controller side
    modport slave (
        input  start, stop, pause, dir, limit, q,
        output t, tff_clr, busy, done, aborted, steps
    );

    // host/bank side
    modport master (
        output start, stop, pause, dir, limit, q,
        input  t, tff_clr, busy, done, aborted, steps
    );
endinterface

`default_nettype wire

// File: rtl/tff_seq_ctrl.sv
// ============================================================================
// Module      : tff_seq_ctrl
// Description : Sequences a bank of WIDTH T flip-flops as an up/down counter
//               from zero to a latched limit, with pause, abort and a
//               saturating count of toggle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,      // asynchronous, active-low
    tff_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    localparam logic [WIDTH:0] c_STEPS_MAX = '1;

    state_t           r_state;
    logic             r_dir;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH:0]   r_steps;
    logic             r_tff_clr;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;

    // Ripple-carry style toggle chains: bit i toggles when all lower bits are
    // 1 (counting up) or all lower bits are 0 (counting down).
    logic [WIDTH-1:0] w_chain_up;
    logic [WIDTH-1:0] w_chain_dn;
    logic             w_match;
    logic             w_run_active;
    logic [WIDTH-1:0] w_t;

    assign w_chain_up[0] = 1'b1;
    assign w_chain_dn[0] = 1'b1;

    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_chain
            assign w_chain_up[i] = w_chain_up[i-1] &  bus.q[i-1];
            assign w_chain_dn[i] = w_chain_dn[i-1] & ~bus.q[i-1];
        end
    endgenerate

    assign w_match      = (bus.q == r_limit);
    // The bank only advances in RUN while not at the limit, paused or stopping.
    assign w_run_active = (r_state == S_RUN) && !w_match && !bus.pause && !bus.stop;
    assign w_t          = w_run_active ? (r_dir ? w_chain_up : w_chain_dn) : '0;

    assign bus.t       = w_t;
    assign bus.tff_clr = r_tff_clr;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.aborted = r_aborted;
    assign bus.steps   = r_steps;

    // Sequencer FSM with registered status outputs and step counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_dir     <= 1'b1;
            r_limit   <= '0;
            r_steps   <= '0;
            r_tff_clr <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_tff_clr <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // start wins over a simultaneous stop here
                    if (bus.start) begin
                        r_dir     <= bus.dir;
                        r_limit   <= bus.limit;
                        r_steps   <= '0;
                        r_tff_clr <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (bus.stop) begin
                        r_aborted <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_ABORT;
                    end else begin
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if ((w_t != '0) && (r_steps != c_STEPS_MAX)) begin
                        r_steps <= r_steps + 1'b1;
                    end
                    if (bus.stop) begin
                        r_aborted <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_ABORT;
                    end else if (w_match) begin
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_ABORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tff_seq_ctrl.sv
// ============================================================================
// Module      : tb_tff_seq_ctrl
// Description : Scoreboard bench for tff_seq_ctrl with a behavioural T flip-
//               flop bank; directed scenarios followed by randomized sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tff_seq_ctrl;

    localparam int W = 4;
    localparam int M = 1 << W;

    typedef struct {
        bit is_abort;
        int steps;
        int q;
        int cycles;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] bank_q = '0;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   t_q[$];
    int   bcnt = 0;
    exp_t e_mon;
    int   t_exp_mon;

    tff_seq_ctrl_if #(.WIDTH(W)) bus ();

    tff_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // behavioural T flip-flop bank with synchronous clear; unaffected by rst
    always @(posedge clk) begin
        if (bus.tff_clr) bank_q <= '0;
        else             bank_q <= bank_q ^ bus.t;
    end
    assign bus.q = bank_q;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int nxt(input int v, input bit up);
        return up ? (v + 1) % M : (v + M - 1) % M;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: per busy cycle compares t and tff_clr, per pulse the outcome
    always @(negedge clk) begin
        if (!rst) begin
            bcnt = 0;
        end else begin
            if (bus.busy) begin
                check("tff_clr_busy", int'(bus.tff_clr), int'(bcnt == 0));
                bcnt++;
                if (t_q.size() == 0) check("t_unexpected", 1, 0);
                else begin
                    t_exp_mon = t_q.pop_front();
                    check("t_run", int'(bus.t), t_exp_mon);
                end
            end else begin
                check("t_idle", int'(bus.t), 0);
                check("tff_clr_idle", int'(bus.tff_clr), 0);
            end
            if (bus.done || bus.aborted) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("done", int'(bus.done), int'(!e_mon.is_abort));
                    check("aborted", int'(bus.aborted), int'(e_mon.is_abort));
                    check("steps", int'(bus.steps), e_mon.steps);
                    check("bank_q", int'(bank_q), e_mon.q);
                    check("busy_cycles", bcnt, e_mon.cycles);
                end
                bcnt = 0;
            end
        end
    end

    // One sequence. stop_step: -1 none, -2 stop in CLR, k>=0 stop once k
    // steps are taken. pause_step/pause_len: hold before step pause_step.
    // noise randomizes ignored inputs and inserts random pauses.
    task automatic run_seq(input bit d, input int lim, input int stop_step,
                           input int pause_step, input int pause_len, input bit noise);
        int   mq, s, cyc, pc;
        bit   pz;
        exp_t e;
        bus.start = 1'b1;
        bus.dir   = d;
        bus.limit = W'(lim);
        bus.stop  = noise ? 1'($urandom % 2) : 1'b0;
        bus.pause = noise ? 1'($urandom % 2) : 1'b0;
        tick();
        // CLR cycle
        bus.start = noise ? 1'($urandom % 2) : 1'b0;
        bus.stop  = (stop_step == -2);
        bus.pause = noise ? 1'($urandom % 2) : 1'b0;
        if (noise) begin
            bus.dir   = 1'($urandom % 2);
            bus.limit = W'($urandom % M);
        end
        t_q.push_back(0);
        cyc = 1; mq = 0; s = 0; pc = 0;
        if (stop_step == -2) begin
            e = '{1'b1, 0, 0, 1};
            exp_q.push_back(e);
            tick();
        end else begin
            tick();
            while (1) begin
                cyc++;
                bus.start = noise ? 1'($urandom % 2) : 1'b0;
                if (noise) begin
                    bus.dir   = 1'($urandom % 2);
                    bus.limit = W'($urandom % M);
                end
                if (s == stop_step || cyc > 200) begin
                    if (cyc > 200) check("run_bound", cyc, 200);
                    bus.stop  = 1'b1;
                    bus.pause = noise ? 1'($urandom % 2) : 1'b0;
                    t_q.push_back(0);
                    e = '{1'b1, s, mq, cyc};
                    exp_q.push_back(e);
                    tick();
                    break;
                end
                bus.stop = 1'b0;
                if (mq == lim) begin
                    bus.pause = noise ? 1'($urandom % 2) : 1'b0;
                    t_q.push_back(0);
                    e = '{1'b0, s, mq, cyc};
                    exp_q.push_back(e);
                    tick();
                    break;
                end
                pz = (s == pause_step && pc < pause_len) || (noise && ($urandom % 4 == 0));
                bus.pause = pz;
                if (pz) begin
                    if (s == pause_step) pc++;
                    t_q.push_back(0);
                end else begin
                    t_q.push_back(mq ^ nxt(mq, d));
                    mq = nxt(mq, d);
                    s++;
                end
                tick();
            end
        end
        // DONE/ABORT cycle: everything here is ignored
        bus.start = noise ? 1'($urandom % 2) : 1'b0;
        bus.stop  = noise ? 1'($urandom % 2) : 1'b0;
        bus.pause = noise ? 1'($urandom % 2) : 1'b0;
        tick();
        bus.start = 1'b0;
        bus.stop  = noise ? 1'($urandom % 2) : 1'b0;
        bus.pause = noise ? 1'($urandom % 2) : 1'b0;
        repeat ($urandom % 3) tick();
        bus.stop  = 1'b0;
        bus.pause = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ss, r;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.pause = 1'b0;
        bus.dir   = 1'b0;
        bus.limit = '0;
        #3;
        check("rst_t", int'(bus.t), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_steps", int'(bus.steps), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick();

        run_seq(1'b1, 5,  -1, -1, 0, 1'b0);
        run_seq(1'b0, 13, -1, -1, 0, 1'b0);
        run_seq(1'b1, 9,  -1,  3, 2, 1'b0);
        run_seq(1'b1, 12,  4, -1, 0, 1'b0);
        run_seq(1'b1, 0,  -1, -1, 0, 1'b1);
        run_seq(1'b0, 7,  -2, -1, 0, 1'b0);

        // reset in RUN: outputs drop immediately, no pulse, bank untouched
        bus.start = 1'b1; bus.dir = 1'b1; bus.limit = W'(12);
        tick();
        bus.start = 1'b0;
        t_q.push_back(0);
        tick();
        t_q.push_back(1);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_t", int'(bus.t), 0);
        check("mid_rst_tff_clr", int'(bus.tff_clr), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_aborted", int'(bus.aborted), 0);
        check("mid_rst_steps", int'(bus.steps), 0);
        check("mid_rst_bank_q", int'(bank_q), 1);
        tick();
        tick();
        rst = 1'b1;
        repeat (4) tick();
        check("post_rst_bank_q", int'(bank_q), 1);
        check("post_rst_steps", int'(bus.steps), 0);

        for (int i = 0; i < 40; i++) begin
            r  = $urandom % 8;
            ss = (r == 0) ? -2 : (r == 1) ? int'($urandom % M) : -1;
            run_seq(1'($urandom % 2), int'($urandom % M), ss, -1, 0, 1'b1);
        end

        repeat (3) tick();
        check("exp_queue_drained", exp_q.size(), 0);
        check("t_queue_drained", t_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
